// File: rtl/ftps_upload_pkg.sv
// Shared constants and register-map helpers for the fingertip upload slave.
package ftps_upload_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int COUNT_LSB = 0;
   localparam int COUNT_W   = 9;
   localparam int EMPTY_BIT = 16;
   localparam int FULL_BIT  = 17;
   localparam int OVF_BIT   = 24;
   localparam int UDF_BIT   = 25;

   function automatic int idx_status(input int n);
      return n;
   endfunction

   function automatic int idx_data(input int n);
      return n + 1;
   endfunction

   function automatic int idx_thresh(input int n);
      return n + 2;
   endfunction

endpackage

// File: rtl/ftps_sample_fifo.sv
// Synchronous sample FIFO; storage is unreset, only pointers and count clear.
module ftps_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PW'(1);
         if (do_pop)  rptr_q <= rptr_q + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ftps_data_upload_v2.sv
// AXI4-Lite slave: control registers, status/threshold, and a poppable
// sample FIFO fed by the fingertip datapath, with a level interrupt.
module ftps_data_upload_v2
   import ftps_upload_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_CTRL_REGS      = 4,
   parameter int FIFO_DEPTH         = 16,
   parameter int SAMPLE_WIDTH       = 32
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   input  logic                              sample_valid,
   input  logic [SAMPLE_WIDTH-1:0]           sample_data,
   output logic                              sample_ready,
   output logic [NUM_CTRL_REGS*32-1:0]       ctrl_out,
   output logic                              irq
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int N  = NUM_CTRL_REGS;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic              awready_q, awready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic [DW-1:0]     ctrl_q [N];
   logic [DW-1:0]     ctrl_d [N];
   logic [COUNT_W-1:0] thresh_q, thresh_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              irq_q, irq_d;

   logic              wr_fire, rd_fire;
   logic              ovf_clr, udf_clr, udf_set;
   logic              fifo_push, fifo_pop;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [COUNT_W-1:0] cnt9;
   logic [SAMPLE_WIDTH-1:0] fifo_rdata;
   logic [DW-1:0]     status_w;
   int                wi, ri;
   logic              unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   ftps_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_WIDTH)
   ) u_fifo (
      .clk_i   (ACLK),
      .rst_ni  (ARESETN),
      .push_i  (fifo_push),
      .wdata_i (sample_data),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Ready looks at the pre-pop count, so a full FIFO drops even on a pop cycle.
   assign sample_ready = !fifo_full;
   assign fifo_push    = sample_valid && !fifo_full;
   assign cnt9         = COUNT_W'(fifo_count);

   always_comb begin
      status_w = '0;
      status_w[COUNT_LSB +: COUNT_W] = cnt9;
      status_w[EMPTY_BIT] = fifo_empty;
      status_w[FULL_BIT]  = fifo_full;
      status_w[OVF_BIT]   = ovf_q;
      status_w[UDF_BIT]   = udf_q;
   end

   always_comb begin
      wi      = int'(S_AXI_AWADDR[AW-1:2]);
      ri      = int'(S_AXI_ARADDR[AW-1:2]);
      wr_fire = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
      rd_fire = arready_q && S_AXI_ARVALID;

      awready_d = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
      bvalid_d  = bvalid_q && !S_AXI_BREADY;
      bresp_d   = bresp_q;
      thresh_d  = thresh_q;
      ovf_clr   = 1'b0;
      udf_clr   = 1'b0;
      for (int k = 0; k < N; k++) ctrl_d[k] = ctrl_q[k];

      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = RESP_OKAY;
         for (int k = 0; k < N; k++) begin
            if (wi == k) begin
               for (int b = 0; b < DW/8; b++) begin
                  if (S_AXI_WSTRB[b])
                     ctrl_d[k][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
               end
            end
         end
         if (wi == idx_status(N)) begin
            if (S_AXI_WSTRB[3]) begin
               ovf_clr = S_AXI_WDATA[OVF_BIT];
               udf_clr = S_AXI_WDATA[UDF_BIT];
            end
         end else if (wi == idx_thresh(N)) begin
            if (S_AXI_WSTRB[0]) thresh_d[7:0] = S_AXI_WDATA[7:0];
            if (S_AXI_WSTRB[1]) thresh_d[8]   = S_AXI_WDATA[8];
         end else if (wi > idx_thresh(N)) begin
            bresp_d = RESP_SLVERR;
         end
      end

      arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
      rvalid_d  = rvalid_q && !S_AXI_RREADY;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      fifo_pop  = 1'b0;
      udf_set   = 1'b0;

      if (rd_fire) begin
         rvalid_d = 1'b1;
         rresp_d  = RESP_OKAY;
         rdata_d  = '0;
         for (int k = 0; k < N; k++) begin
            if (ri == k) rdata_d = ctrl_q[k];
         end
         if (ri == idx_status(N)) begin
            rdata_d = status_w;
         end else if (ri == idx_data(N)) begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               rdata_d  = DW'(fifo_rdata);
            end else begin
               rresp_d = RESP_SLVERR;
               udf_set = 1'b1;
            end
         end else if (ri == idx_thresh(N)) begin
            rdata_d = DW'(thresh_q);
         end else if (ri > idx_thresh(N)) begin
            rresp_d = RESP_SLVERR;
         end
      end

      // A fresh event in the same cycle as its W1C wins over the clear.
      ovf_d = (ovf_q && !ovf_clr) || (sample_valid && fifo_full);
      udf_d = (udf_q && !udf_clr) || udf_set;
      irq_d = ((thresh_q != '0) && (cnt9 >= thresh_q)) || ovf_q;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         thresh_q  <= '0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         irq_q     <= 1'b0;
         for (int k = 0; k < N; k++) ctrl_q[k] <= '0;
      end else begin
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         thresh_q  <= thresh_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         irq_q     <= irq_d;
         for (int k = 0; k < N; k++) ctrl_q[k] <= ctrl_d[k];
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_ctrl
      assign ctrl_out[32*k +: 32] = ctrl_q[k];
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_ftps_data_upload_v2.sv
// Directed bench for ftps_data_upload_v2 with hand-computed expectations.
module tb_ftps_data_upload_v2;

   localparam logic [5:0] A_CTRL0  = 6'h00;
   localparam logic [5:0] A_STATUS = 6'h10;
   localparam logic [5:0] A_DATA   = 6'h14;
   localparam logic [5:0] A_THRESH = 6'h18;
   localparam logic [5:0] A_UNMAP  = 6'h1C;

   logic          ACLK = 1'b0;
   logic          ARESETN;
   logic [5:0]    S_AXI_AWADDR;
   logic [2:0]    S_AXI_AWPROT;
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [5:0]    S_AXI_ARADDR;
   logic [2:0]    S_AXI_ARPROT;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;
   logic          sample_valid;
   logic [31:0]   sample_data;
   logic          sample_ready;
   logic [127:0]  ctrl_out;
   logic          irq;

   int            n_vec = 0;
   int            n_bad = 0;
   logic          irq_snap;

   ftps_data_upload_v2 dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .sample_valid  (sample_valid),
      .sample_data   (sample_data),
      .sample_ready  (sample_ready),
      .ctrl_out      (ctrl_out),
      .irq           (irq)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
      int n;
      S_AXI_AWADDR  = a;
      S_AXI_WDATA   = d;
      S_AXI_WSTRB   = s;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end
      while (!S_AXI_AWREADY && n < 20);
      check("wr_awready", S_AXI_AWREADY, 1'b1);
      check("wr_wready", S_AXI_WREADY, 1'b1);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      n = 0;
      do begin @(negedge ACLK); n++; end
      while (!S_AXI_BVALID && n < 20);
      check("wr_bvalid", S_AXI_BVALID, 1'b1);
      resp = S_AXI_BRESP;
      @(posedge ACLK); #1;
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                           output logic [1:0] resp);
      int n;
      S_AXI_ARADDR  = a;
      S_AXI_ARVALID = 1'b1;
      n = 0;
      do begin @(negedge ACLK); n++; end
      while (!S_AXI_ARREADY && n < 20);
      check("rd_arready", S_AXI_ARREADY, 1'b1);
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      n = 0;
      do begin @(negedge ACLK); n++; end
      while (!S_AXI_RVALID && n < 20);
      check("rd_rvalid", S_AXI_RVALID, 1'b1);
      d        = S_AXI_RDATA;
      resp     = S_AXI_RRESP;
      irq_snap = irq;
      @(posedge ACLK); #1;
   endtask

   task automatic push_n(input logic [31:0] base, input int n);
      sample_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         sample_data = base + 32'(i);
         @(posedge ACLK); #1;
      end
      sample_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rs;
      logic [1:0]  ws;

      ARESETN       = 1'b0;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = '0;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = '0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b1;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = '0;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      sample_valid  = 1'b0;
      sample_data   = '0;
      irq_snap      = 1'b0;

      repeat (3) @(posedge ACLK);
      #1;
      check("rst_awready", S_AXI_AWREADY, 1'b0);
      check("rst_wready", S_AXI_WREADY, 1'b0);
      check("rst_bvalid", S_AXI_BVALID, 1'b0);
      check("rst_bresp", S_AXI_BRESP, 2'b00);
      check("rst_arready", S_AXI_ARREADY, 1'b0);
      check("rst_rvalid", S_AXI_RVALID, 1'b0);
      check("rst_rresp", S_AXI_RRESP, 2'b00);
      check("rst_rdata", S_AXI_RDATA, 32'h0);
      check("rst_ctrl", ctrl_out, 128'h0);
      check("rst_irq", irq, 1'b0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      check("rst_sready", sample_ready, 1'b1);

      for (int k = 0; k < 4; k++) begin
         axi_write(A_CTRL0 + 6'(4*k), 32'(k + 1), 4'hF, ws);
         check("ctrl_bresp", ws, 2'b00);
      end
      for (int k = 0; k < 4; k++) begin
         axi_read(A_CTRL0 + 6'(4*k), rd, rs);
         check("ctrl_rdata", rd, 32'(k + 1));
         check("ctrl_rresp", rs, 2'b00);
      end
      check("ctrl_out", ctrl_out,
            128'h00000004_00000003_00000002_00000001);

      axi_write(6'h04, 32'hFFFFFFFF, 4'hF, ws);
      axi_write(6'h04, 32'h12345678, 4'b0101, ws);
      axi_read(6'h04, rd, rs);
      check("strb_rdata", rd, 32'hFF34FF78);

      push_n(32'hA, 3);
      axi_read(A_STATUS, rd, rs);
      check("st_cnt3", rd, 32'h00000003);
      for (int i = 0; i < 3; i++) begin
         axi_read(A_DATA, rd, rs);
         check("pop_data", rd, 32'hA + 32'(i));
         check("pop_rresp", rs, 2'b00);
      end
      axi_read(A_DATA, rd, rs);
      check("udf_rdata", rd, 32'h0);
      check("udf_rresp", rs, 2'b10);
      axi_read(A_STATUS, rd, rs);
      check("st_udf", rd, 32'h02010000);
      axi_write(A_STATUS, 32'h02000000, 4'hF, ws);
      axi_read(A_STATUS, rd, rs);
      check("st_udf_clr", rd, 32'h00010000);

      axi_write(A_THRESH, 32'hFFFFFE04, 4'hF, ws);
      axi_read(A_THRESH, rd, rs);
      check("thresh_rd", rd, 32'h00000004);
      push_n(32'h10, 4);
      check("irq_lag", irq, 1'b0);
      @(posedge ACLK); #1;
      check("irq_rise", irq, 1'b1);
      axi_read(A_DATA, rd, rs);
      check("thr_pop", rd, 32'h10);
      check("irq_hold", irq_snap, 1'b1);
      check("irq_fall", irq, 1'b0);
      for (int i = 1; i < 4; i++) begin
         axi_read(A_DATA, rd, rs);
         check("thr_drain", rd, 32'h10 + 32'(i));
      end
      axi_write(A_THRESH, 32'h0, 4'hF, ws);

      sample_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i == 16) check("full_sready", sample_ready, 1'b0);
         sample_data = 32'h100 + 32'(i);
         @(posedge ACLK); #1;
      end
      sample_valid = 1'b0;
      @(posedge ACLK); #1;
      check("ovf_irq", irq, 1'b1);
      axi_read(A_STATUS, rd, rs);
      check("st_full_ovf", rd, 32'h01020010);
      axi_write(A_STATUS, 32'h01000000, 4'b1000, ws);
      axi_read(A_STATUS, rd, rs);
      check("st_ovf_clr", rd, 32'h00020010);
      check("ovf_irq_clr", irq, 1'b0);
      for (int i = 0; i < 16; i++) begin
         axi_read(A_DATA, rd, rs);
         check("full_drain", rd, 32'h100 + 32'(i));
      end
      axi_read(A_STATUS, rd, rs);
      check("st_drained", rd, 32'h00010000);

      axi_write(A_UNMAP, 32'hDEADBEEF, 4'hF, ws);
      check("unm_bresp", ws, 2'b10);
      axi_read(A_UNMAP, rd, rs);
      check("unm_rdata", rd, 32'h0);
      check("unm_rresp", rs, 2'b10);
      axi_write(A_DATA, 32'h55, 4'hF, ws);
      check("data_wr_bresp", ws, 2'b00);
      check("unm_ctrl", ctrl_out,
            128'h00000004_00000003_FF34FF78_00000001);
      axi_read(A_THRESH, rd, rs);
      check("unm_thresh", rd, 32'h0);
      axi_read(A_STATUS, rd, rs);
      check("unm_status", rd, 32'h00010000);

      axi_write(A_THRESH, 32'h1, 4'hF, ws);
      push_n(32'h77, 2);
      @(posedge ACLK); #1;
      check("pre_rst_irq", irq, 1'b1);
      S_AXI_BREADY  = 1'b0;
      S_AXI_AWADDR  = A_CTRL0;
      S_AXI_WDATA   = 32'h55;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      for (int n = 0; n < 20 && !S_AXI_AWREADY; n++) @(negedge ACLK);
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      @(negedge ACLK);
      check("mid_bvalid", S_AXI_BVALID, 1'b1);
      ARESETN = 1'b0;
      #1;
      check("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
      check("mid_rst_ctrl", ctrl_out, 128'h0);
      check("mid_rst_irq", irq, 1'b0);
      check("mid_rst_sready", sample_ready, 1'b1);
      @(posedge ACLK); #1;
      ARESETN      = 1'b1;
      S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1;
      axi_read(A_STATUS, rd, rs);
      check("post_rst_status", rd, 32'h00010000);
      axi_read(A_THRESH, rd, rs);
      check("post_rst_thresh", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ftps_data_upload_v2.md
Name: ftps_data_upload_v2

Overview:
- Parametrised AXI4-Lite slave that replaces the fixed four-register upload block in the fingertip air-writing pipeline.
- Provides NUM_CTRL_REGS read/write control registers with byte strobes.
- Adds an upload FIFO: the fingertip-tracking datapath pushes coordinate samples into it, and the PS pops them through a register read.
- Adds a status register, a programmable IRQ threshold and a level interrupt to the PS.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; must cover (NUM_CTRL_REGS+3) words.
NUM_CTRL_REGS, 4, number of RW control registers, 1..12.
FIFO_DEPTH, 16, sample FIFO depth; power of two, 2..256.
SAMPLE_WIDTH, 32, sample width; at most 32, zero-extended on read.

Ports:
ACLK in 1 system clock; all logic is on its rising edge.
ARESETN in 1 asynchronous active-low reset.
S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH write address.
S_AXI_AWPROT in 3 ignored.
S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1: write address handshake.
S_AXI_WDATA in 32 / S_AXI_WSTRB in 4: write data and byte strobes.
S_AXI_WVALID in 1 / S_AXI_WREADY out 1: write data handshake.
S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1: write response.
S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH read address.
S_AXI_ARPROT in 3 ignored.
S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1: read address handshake.
S_AXI_RDATA out 32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1: read data and response.
sample_valid in 1 / sample_data in SAMPLE_WIDTH / sample_ready out 1: sample push interface.
ctrl_out out NUM_CTRL_REGS*32 flattened control registers; register k occupies bits [32k+31:32k].
irq out 1 level interrupt.

Behaviour:
- Reset (asynchronous assertion, synchronous release). All of the following are 0: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA, ctrl_out, irq, FIFO pointers/count, sticky bits, THRESH. sample_ready is 1 once ARESETN is high.
- Address map. Word index = addr[ADDR_W-1:2]; addr[1:0] ignored.
  - 0..N-1: CTRL[k], RW.
  - N: STATUS, RO except W1C. Bits [8:0] fill count; [16] empty; [17] full; [24] overflow sticky; [25] underflow sticky.
  - N+1: DATA, RO; a read pops one sample.
  - N+2: THRESH, RW; bits [8:0] used, upper bits read 0.
  - Any other index: no register.
- Write channel.
  - Accept only when AWVALID && WVALID && !BVALID. AWREADY and WREADY pulse high together for exactly one cycle.
  - BVALID rises the cycle after acceptance and holds until BREADY; no new write is accepted while BVALID=1.
  - Bytes are updated where WSTRB[i]=1.
  - STATUS write: WDATA[24]=1 clears overflow; WDATA[25]=1 clears underflow (strobe of byte 3 required).
  - DATA write is ignored and responds BRESP=OKAY.
  - Unmapped address: no state change, BRESP=SLVERR (2'b10).
- Read channel.
  - ARREADY pulses for one cycle when ARVALID && !RVALID && !ARREADY.
  - RDATA/RRESP are registered; RVALID rises the next cycle and holds, with data stable, until RREADY.
  - Unmapped address: RDATA=0, RRESP=SLVERR.
- FIFO pop.
  - Occurs in the ARREADY cycle for a DATA read when not empty. RDATA is the head sample, zero-extended.
  - DATA read while empty: RDATA=0, RRESP=SLVERR, underflow set, pointers unchanged.
- FIFO push.
  - sample_ready = !full, combinational from count.
  - Push when sample_valid && !full.
  - sample_valid while full drops the sample and sets overflow; count stays FIFO_DEPTH.
  - Push and pop in the same cycle: both occur and count is unchanged. When full, the push is still dropped, because ready uses the pre-pop count.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Read/write race: a STATUS read and a W1C write in the same cycle return the pre-clear value.
- IRQ.
  - Registered: irq = (THRESH != 0) && (count >= THRESH) || overflow.
  - Updates one cycle after the causing event.
- Reset mid-transaction: any pending B/R response is abandoned, valid outputs return to 0, and FIFO contents are discarded.

Decomposition:
- Package ftps_upload_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - STATUS bit positions (COUNT_LSB=0, EMPTY_BIT=16, FULL_BIT=17, OVF_BIT=24, UDF_BIT=25);
  - helper functions idx_status(N), idx_data(N), idx_thresh(N).
- One sub-module, ftps_sample_fifo: synchronous FIFO with async active-low reset, push/pop, count/full/empty outputs, parameters DEPTH and WIDTH.
- The AXI decode and register file stay in the top level.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to CTRL0..3, then read each back -> RDATA matches, RRESP=OKAY, ctrl_out=0x00000004_00000003_00000002_00000001.
- CTRL1=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> read returns 0xFF34FF78.
- Push 0xA,0xB,0xC -> STATUS reads count=3, empty=0. Three DATA reads return 0xA,0xB,0xC. A fourth DATA read returns 0 with SLVERR, and underflow=1.
- THRESH=4, push 4 samples -> irq rises one cycle after the 4th push. One pop -> irq falls the following cycle.
- Push 17 samples at depth 16 -> sample_ready=0 after the 16th, full=1, overflow=1, irq=1. Write STATUS 0x01000000 -> overflow=0, count still 16.
- Read/write unmapped index N+3 -> SLVERR, RDATA=0, no state change. Assert ARESETN low while BVALID=1 -> BVALID=0 immediately, all registers 0.
